// File: rtl/uart_rx_rcu_if.sv
// Control/status bundle between the RX control unit and its counters,
// stop-bit checker and data buffer.
interface uart_rx_rcu_if #(
    parameter int ERR_CNT_BITS = 4
);
    logic                    start_bit_detected;
    logic                    shift_strobe;
    logic                    packet_done;
    logic                    framing_error;
    logic                    timer_clear;
    logic                    enable_timer;
    logic                    sbc_clear;
    logic                    sbc_enable;
    logic                    load_buffer;
    logic                    shift_enable;
    logic                    error_flag;
    logic [ERR_CNT_BITS-1:0] err_count;

    modport master (
        input  start_bit_detected,
        input  shift_strobe,
        input  packet_done,
        input  framing_error,
        output timer_clear,
        output enable_timer,
        output sbc_clear,
        output sbc_enable,
        output load_buffer,
        output shift_enable,
        output error_flag,
        output err_count
    );

    modport slave (
        output start_bit_detected,
        output shift_strobe,
        output packet_done,
        output framing_error,
        input  timer_clear,
        input  enable_timer,
        input  sbc_clear,
        input  sbc_enable,
        input  load_buffer,
        input  shift_enable,
        input  error_flag,
        input  err_count
    );
endinterface

// File: rtl/uart_rx_rcu.sv
// UART RX control unit: sequences counters, stop-bit check and buffer load.
// Optional RECEIVE watchdog with ABORT state: define RCU_WATCHDOG_EN.
module uart_rx_rcu #(
    parameter int ERR_CNT_BITS    = 4,
    parameter int WATCHDOG_CYCLES = 1024
) (
    input logic         clk,
    input logic         n_rst,
    uart_rx_rcu_if.master bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CLEAR     = 3'd1,
        RECEIVE   = 3'd2,
        SBC_SET   = 3'd3,
        SBC_CHECK = 3'd4,
        LOAD      = 3'd5
`ifdef RCU_WATCHDOG_EN
        ,
        ABORT     = 3'd6
`endif
    } state_t;

    state_t state;
    state_t nxt;

    logic                    err_evt;
    logic                    eflag_q;
    logic [ERR_CNT_BITS-1:0] cnt_q;

    if (WATCHDOG_CYCLES < 2) begin : g_wd_bad
        $error("WATCHDOG_CYCLES must be at least 2");
    end

`ifdef RCU_WATCHDOG_EN
    localparam int WD_W = $clog2(WATCHDOG_CYCLES) + 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(WATCHDOG_CYCLES - 1);

    logic [WD_W-1:0] wd;
    logic            wd_hit;

    // packet_done on the limit cycle still wins over the abort
    assign wd_hit = (state == RECEIVE) && (wd == WD_MAX) &&
                    !bus.packet_done;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            wd <= '0;
        end else if (state == CLEAR) begin
            wd <= '0;
        end else if (state == RECEIVE) begin
            wd <= wd + 1'b1;
        end
    end

    assign err_evt = ((state == SBC_CHECK) && bus.framing_error) || wd_hit;
`else
    assign err_evt = (state == SBC_CHECK) && bus.framing_error;
`endif

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (bus.start_bit_detected) nxt = CLEAR;
            end
            CLEAR: nxt = RECEIVE;
            RECEIVE: begin
                if (bus.packet_done) nxt = SBC_SET;
`ifdef RCU_WATCHDOG_EN
                else if (wd_hit) nxt = ABORT;
`endif
            end
            SBC_SET: nxt = SBC_CHECK;
            SBC_CHECK: nxt = bus.framing_error ? IDLE : LOAD;
            LOAD: nxt = IDLE;
`ifdef RCU_WATCHDOG_EN
            ABORT: nxt = IDLE;
`endif
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.timer_clear  = 1'b0;
        bus.enable_timer = 1'b0;
        bus.sbc_clear    = 1'b0;
        bus.sbc_enable   = 1'b0;
        bus.load_buffer  = 1'b0;
        case (state)
            CLEAR: begin
                bus.timer_clear = 1'b1;
                bus.sbc_clear   = 1'b1;
            end
            RECEIVE: bus.enable_timer = 1'b1;
            SBC_SET: bus.sbc_enable = 1'b1;
            LOAD: bus.load_buffer = 1'b1;
`ifdef RCU_WATCHDOG_EN
            ABORT: begin
                bus.timer_clear = 1'b1;
                bus.sbc_clear   = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign bus.shift_enable = bus.shift_strobe && (state == RECEIVE);

    // error_flag reports the last packet only; err_count sticks at all-ones
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            eflag_q <= 1'b0;
            cnt_q   <= '0;
        end else if (err_evt) begin
            eflag_q <= 1'b1;
            if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
        end else if (state == CLEAR) begin
            eflag_q <= 1'b0;
        end
    end

    assign bus.error_flag = eflag_q;
    assign bus.err_count  = cnt_q;

endmodule

// File: doc/uart_rx_rcu.md
Name: uart_rx_rcu

Overview:
- Receiver control unit for the serial RX path.
- Sits directly downstream of the bit-period and bit-count flex counters. It consumes their rollover flags as shift_strobe and packet_done.
- Drives the counters' clear and enable inputs, sequences stop-bit checking, and issues the load pulse to the RX data buffer.
- Also keeps a saturating framing-error tally for status readout.

Parameters:
ERR_CNT_BITS, 4, width of saturating framing/timeout error counter
WATCHDOG_CYCLES, 1024, max clk cycles in RECEIVE before abort (used only with RCU_WATCHDOG_EN)

Ports:
clk  input  1  system clock, all state updates on rising edge
n_rst  input  1  synchronous active-low reset, sampled on rising edge of clk
start_bit_detected  input  1  one-cycle pulse from start-bit edge detector
shift_strobe  input  1  rollover_flag of bit-period counter; used only for the rx_active shift qualifier
packet_done  input  1  rollover_flag of bit counter; all data+stop bits sampled
framing_error  input  1  stop-bit checker result, valid one cycle after sbc_enable
timer_clear  output  1  clear for both flex counters
enable_timer  output  1  count_enable for bit-period counter
sbc_clear  output  1  clear for stop-bit checker
sbc_enable  output  1  capture strobe for stop-bit checker
load_buffer  output  1  one-cycle write pulse to RX data buffer
shift_enable  output  1  shift_strobe qualified by RECEIVE state
error_flag  output  1  last packet failed (framing or timeout)
err_count  output  ERR_CNT_BITS  saturating count of failed packets

Behaviour:
- Reset: on any edge with n_rst=0, state<=IDLE, error_flag<=0, err_count<=0, watchdog<=0. All control outputs are 0 in IDLE. Reset mid-packet aborts with no load_buffer pulse.
- Control outputs are Moore-decoded from the registered state. shift_enable = shift_strobe AND (state==RECEIVE), combinational.

States and transitions (evaluated each clk edge):
- IDLE: all pulses 0. If start_bit_detected=1, go to CLEAR; else stay.
- CLEAR: timer_clear=1, sbc_clear=1. Next state is RECEIVE, unconditional. error_flag<=0 on this edge.
- RECEIVE: enable_timer=1. If packet_done=1, go to SBC_SET; else stay.
- SBC_SET: sbc_enable=1. Next state is SBC_CHECK, unconditional.
- SBC_CHECK: all pulses 0.
  - If framing_error=1: go to IDLE; error_flag<=1; err_count increments.
  - Else go to LOAD.
- LOAD: load_buffer=1. Next state is IDLE.
- ABORT: exists only with RCU_WATCHDOG_EN. timer_clear=1, sbc_clear=1. Next state is IDLE.

Latency and counting rules:
- Latency: start_bit_detected to enable_timer high = 2 edges.
- Latency: packet_done to load_buffer = 3 edges (SBC_SET, SBC_CHECK, LOAD).
- err_count saturates at 2^ERR_CNT_BITS-1; it never wraps. It is cleared only by reset.

Boundary rules:
- start_bit_detected outside IDLE is ignored. No restart occurs mid-packet.
- packet_done outside RECEIVE is ignored.
- packet_done coinciding with start_bit_detected in RECEIVE: packet_done wins.
- framing_error is sampled only in SBC_CHECK.
- Back-to-back packets: start_bit_detected in the cycle of LOAD is ignored. It is accepted from IDLE the next cycle.

Optional Feature:
RCU_WATCHDOG_EN
- Defined:
  - A watchdog counter of width $clog2(WATCHDOG_CYCLES)+1 resets to 0 on entry to RECEIVE and increments each cycle in RECEIVE.
  - If it reaches WATCHDOG_CYCLES-1 without packet_done, the next state is ABORT. On that edge, error_flag<=1 and err_count increments (saturating).
  - packet_done on the same edge as the watchdog limit takes priority (goes to SBC_SET).
- Undefined: no watchdog logic and no ABORT state; RECEIVE waits indefinitely for packet_done.

Test Plan:
- Reset: n_rst=0 for 2 edges mid-RECEIVE -> state IDLE, all outputs 0, err_count=0. An asynchronous-only drop of n_rst between edges has no effect.
- Good packet: start_bit_detected pulse, then packet_done pulse 80 cycles later, framing_error=0 -> waveform below.
  - timer_clear and sbc_clear high 1 cycle, then enable_timer high.
  - sbc_enable 1 cycle after packet_done.
  - load_buffer exactly 3 edges after packet_done.
  - error_flag=0, err_count unchanged.
- Framing error: same stimulus with framing_error=1 during SBC_CHECK -> no load_buffer; error_flag=1; err_count 0->1. The next start_bit_detected clears error_flag in CLEAR.
- Saturation: 20 consecutive framing-error packets with ERR_CNT_BITS=4 -> err_count stays at 15.
- Ignored events: start_bit_detected during RECEIVE and packet_done during IDLE -> no state change and no extra pulses. shift_enable tracks shift_strobe only during RECEIVE.
- Watchdog (RCU_WATCHDOG_EN, WATCHDOG_CYCLES=16): start, no packet_done -> ABORT after 16 cycles in RECEIVE. ABORT pulses timer_clear, error_flag=1, err_count+1, then IDLE. With the macro undefined, the same stimulus stays in RECEIVE for 1000 cycles.
